// File: rtl/rgb_pkg.sv
// Shared hue encodings and helpers for the RGB sequencer and monitor.
// Patterns are {R,G,B}; hue indices step modulo six.
package rgb_pkg;

  typedef enum logic [2:0] {
    RED     = 3'd0,
    YELLOW  = 3'd1,
    GREEN   = 3'd2,
    CYAN    = 3'd3,
    BLUE    = 3'd4,
    MAGENTA = 3'd5
  } hue_t;

  localparam int NUM_HUES = 6;

  localparam logic [2:0] PAT_RED     = 3'b100;
  localparam logic [2:0] PAT_YELLOW  = 3'b110;
  localparam logic [2:0] PAT_GREEN   = 3'b010;
  localparam logic [2:0] PAT_CYAN    = 3'b011;
  localparam logic [2:0] PAT_BLUE    = 3'b001;
  localparam logic [2:0] PAT_MAGENTA = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  function automatic logic hue_valid_pat(
    input logic [2:0] p
  );
    return (p != 3'b000) && (p != 3'b111);
  endfunction

  function automatic hue_t pat_to_hue(
    input logic [2:0] p
  );
    hue_t h;
    case (p)
      PAT_YELLOW:  h = YELLOW;
      PAT_GREEN:   h = GREEN;
      PAT_CYAN:    h = CYAN;
      PAT_BLUE:    h = BLUE;
      PAT_MAGENTA: h = MAGENTA;
      default:     h = RED;
    endcase
    return h;
  endfunction

  function automatic hue_t hue_next(
    input hue_t h
  );
    return (h == MAGENTA) ? RED
                          : hue_t'(h + 3'd1);
  endfunction

  function automatic hue_t hue_prev(
    input hue_t h
  );
    return (h == RED) ? MAGENTA
                      : hue_t'(h - 3'd1);
  endfunction

endpackage

// File: rtl/rgb_glitch_filter.sv
// Synchronizes the three RGB lines and accepts a pattern only
// after it has been seen unchanged for STABLE_CYCLES samples.
module rgb_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rgb,
  output logic [2:0] pattern,
  output logic       accept
);

  localparam int SW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX =
    SW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][2:0] sy;
  logic [2:0]                  synced;
  logic [2:0]                  cand;
  logic [2:0]                  acc;
  logic [SW-1:0]               stab;

  assign synced  = sy[SYNC_STAGES-1];
  assign accept  = (stab == STAB_MAX) && (cand != acc);
  assign pattern = cand;

  // Multi-flop synchronizer chain for the asynchronous lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy <= '0;
    end else begin
      sy <= {sy[SYNC_STAGES-2:0], rgb};
    end
  end

  // Candidate tracking, stability count and accepted pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      stab <= '0;
      acc  <= '0;
    end else begin
      if (synced != cand) begin
        cand <= synced;
        stab <= '0;
      end else if (stab != STAB_MAX) begin
        stab <= stab + 1'b1;
      end
      if (accept) begin
        acc <= cand;
      end
    end
  end

endmodule

// File: rtl/rgb_hue_monitor.sv
// Recovers the displayed hue from the RGB drive lines and tracks
// step direction, dwell time, sequence errors and cycle lock.
module rgb_hue_monitor
  import rgb_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int DWELL_W       = 24,
  parameter int NOMINAL_DWELL = 2_000_001,
  parameter int DWELL_TOL     = 1000,
  parameter int LOCK_STEPS    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rgb_r,
  input  logic               rgb_g,
  input  logic               rgb_b,
  output logic               hue_valid,
  output logic [2:0]         hue_idx,
  output logic               hue_strobe,
  output logic               dir_fwd,
  output logic               seq_err,
  output logic [DWELL_W-1:0] dwell_cycles,
  output logic               dwell_ok,
  output logic               locked
);

  localparam int RW = $clog2(LOCK_STEPS + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_STEPS);
  localparam logic [DWELL_W-1:0] D_MAX = '1;
  localparam logic [DWELL_W:0] NOM =
    (DWELL_W + 1)'(NOMINAL_DWELL);
  localparam logic [DWELL_W:0] TOL =
    (DWELL_W + 1)'(DWELL_TOL);

  logic [2:0]         pat;
  logic               accept;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_now;
  logic [DWELL_W:0]   dwell_ext;
  logic [DWELL_W:0]   diff;
  logic               ok_now;
  logic               new_valid;
  hue_t               new_hue;
  hue_t               cur;
  logic               step_fwd;
  logic               step_rev;

  mon_state_t         state;
  mon_state_t         state_n;
  logic [RW-1:0]      run;
  logic [RW-1:0]      run_n;
  logic               has_dir;
  logic               has_dir_n;
  logic               dir_n;
  logic               err_n;

  rgb_glitch_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .rgb     ({rgb_r, rgb_g, rgb_b}),
    .pattern (pat),
    .accept  (accept)
  );

  assign hue_idx   = cur;
  assign new_valid = hue_valid_pat(pat);
  assign new_hue   = pat_to_hue(pat);
  assign step_fwd  = (new_hue == hue_next(cur));
  assign step_rev  = (new_hue == hue_prev(cur));

  // Dwell of the pattern being left, and its distance from nominal.
  always_comb begin
    dwell_now = (cnt == D_MAX) ? D_MAX : cnt + 1'b1;
    dwell_ext = {1'b0, dwell_now};
    diff      = (dwell_ext >= NOM) ? dwell_ext - NOM
                                   : NOM - dwell_ext;
    ok_now    = (diff <= TOL);
  end

  // Next-state and step classification on each acceptance.
  always_comb begin
    state_n   = state;
    run_n     = run;
    has_dir_n = has_dir;
    dir_n     = dir_fwd;
    err_n     = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (new_valid) begin
            state_n   = TRACK;
            run_n     = '0;
            has_dir_n = 1'b0;
          end
        end
        default: begin
          if (!new_valid) begin
            state_n   = IDLE;
            run_n     = '0;
            has_dir_n = 1'b0;
            err_n     = 1'b1;
          end else if (step_fwd || step_rev) begin
            dir_n     = step_fwd;
            has_dir_n = 1'b1;
            if (has_dir && (dir_fwd == step_fwd)
                && ok_now) begin
              run_n = (run == RUN_MAX) ? run
                                       : run + 1'b1;
            end else begin
              run_n = ok_now ? RW'(1) : '0;
            end
            state_n = (run_n == RUN_MAX) ? LOCKED
                                         : TRACK;
          end else begin
            state_n   = TRACK;
            run_n     = '0;
            has_dir_n = 1'b0;
            err_n     = 1'b1;
          end
        end
      endcase
    end
    if ((state_n == LOCKED) && (run_n != RUN_MAX)) begin
      state_n = TRACK;
    end
  end

  // FSM state, run length, direction and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run     <= '0;
      has_dir <= 1'b0;
      dir_fwd <= 1'b0;
      seq_err <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_n;
      run     <= run_n;
      has_dir <= has_dir_n;
      dir_fwd <= dir_n;
      seq_err <= err_n;
      locked  <= (state_n == LOCKED);
    end
  end

  // Hue register, dwell capture and saturating dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hue_strobe   <= 1'b0;
      hue_valid    <= 1'b0;
      cur          <= RED;
      dwell_cycles <= '0;
      dwell_ok     <= 1'b0;
      cnt          <= '0;
    end else begin
      hue_strobe <= accept;
      if (accept) begin
        hue_valid    <= new_valid;
        dwell_cycles <= dwell_now;
        dwell_ok     <= (state == IDLE) ? 1'b0 : ok_now;
        cnt          <= '0;
        if (new_valid) begin
          cur <= new_hue;
        end
      end else if (cnt != D_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_hue_monitor.sv
// Directed scoreboard bench for rgb_hue_monitor.
// Expected strobe results are queued as each pattern is driven.
module tb_rgb_hue_monitor;

  localparam int DW = 24;

  typedef struct {
    int v;
    int idx;
    int dir;
    int err;
    int ok;
    int lck;
    int dwell;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rgb_r;
  logic          rgb_g;
  logic          rgb_b;
  logic          hue_valid;
  logic [2:0]    hue_idx;
  logic          hue_strobe;
  logic          dir_fwd;
  logic          seq_err;
  logic [DW-1:0] dwell_cycles;
  logic          dwell_ok;
  logic          locked;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  rgb_hue_monitor #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .DWELL_W       (DW),
    .NOMINAL_DWELL (100),
    .DWELL_TOL     (2),
    .LOCK_STEPS    (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rgb_r        (rgb_r),
    .rgb_g        (rgb_g),
    .rgb_b        (rgb_b),
    .hue_valid    (hue_valid),
    .hue_idx      (hue_idx),
    .hue_strobe   (hue_strobe),
    .dir_fwd      (dir_fwd),
    .seq_err      (seq_err),
    .dwell_cycles (dwell_cycles),
    .dwell_ok     (dwell_ok),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_valid"}, 32'(hue_valid), 0);
    chk({pfx, "_idx"}, 32'(hue_idx), 0);
    chk({pfx, "_strobe"}, 32'(hue_strobe), 0);
    chk({pfx, "_dir"}, 32'(dir_fwd), 0);
    chk({pfx, "_err"}, 32'(seq_err), 0);
    chk({pfx, "_dwell"}, 32'(dwell_cycles), 0);
    chk({pfx, "_ok"}, 32'(dwell_ok), 0);
    chk({pfx, "_lock"}, 32'(locked), 0);
  endtask

  task automatic step(input logic [2:0] p, input int n,
                      input int v, input int idx,
                      input int dir, input int err,
                      input int ok, input int lck,
                      input int dwell);
    {rgb_r, rgb_g, rgb_b} = p;
    q.push_back('{v, idx, dir, err, ok, lck, dwell});
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: pop one expectation per strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (hue_strobe === 1'b1) begin
        chk("strobe_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("valid", 32'(hue_valid), e.v);
          chk("idx", 32'(hue_idx), e.idx);
          chk("dir", 32'(dir_fwd), e.dir);
          chk("seq_err", 32'(seq_err), e.err);
          chk("dwell_ok", 32'(dwell_ok), e.ok);
          chk("locked", 32'(locked), e.lck);
          if (e.dwell >= 0) begin
            chk("dwell", 32'(dwell_cycles), e.dwell);
          end
        end
      end else begin
        chk("seq_err_alone", 32'(seq_err), 0);
      end
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    {rgb_r, rgb_g, rgb_b} = 3'b100;
    repeat (3) @(negedge clk);
    chk_zero("rst");

    q.push_back('{1, 0, 0, 0, 0, 0, -1});
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (hue_strobe === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("first_latency", 32'(lat), 7);
    repeat (93) @(negedge clk);

    // forward cycle to lock
    step(3'b110, 100, 1, 1, 1, 0, 1, 0, 100);
    step(3'b010, 100, 1, 2, 1, 0, 1, 0, 100);
    step(3'b011, 100, 1, 3, 1, 0, 1, 0, 100);
    step(3'b001, 100, 1, 4, 1, 0, 1, 0, 100);
    step(3'b101, 100, 1, 5, 1, 0, 1, 0, 100);
    step(3'b100, 40, 1, 0, 1, 0, 1, 1, 100);

    // short glitch inside RED
    {rgb_r, rgb_g, rgb_b} = 3'b110;
    repeat (3) @(negedge clk);
    {rgb_r, rgb_g, rgb_b} = 3'b100;
    repeat (57) @(negedge clk);
    chk("glitch_idx", 32'(hue_idx), 0);
    chk("glitch_lock", 32'(locked), 1);

    // 4-cycle pulse is accepted
    step(3'b110, 4, 1, 1, 1, 0, 1, 1, 100);
    step(3'b100, 100, 1, 0, 0, 0, 0, 0, 4);

    // reverse steps, then a skip
    step(3'b101, 100, 1, 5, 0, 0, 1, 0, 100);
    step(3'b001, 100, 1, 4, 0, 0, 1, 0, 100);
    step(3'b110, 100, 1, 1, 0, 1, 1, 0, 100);

    // relock forward
    step(3'b010, 100, 1, 2, 1, 0, 1, 0, 100);
    step(3'b011, 100, 1, 3, 1, 0, 1, 0, 100);
    step(3'b001, 100, 1, 4, 1, 0, 1, 0, 100);
    step(3'b101, 100, 1, 5, 1, 0, 1, 0, 100);
    step(3'b100, 100, 1, 0, 1, 0, 1, 0, 100);
    step(3'b110, 100, 1, 1, 1, 0, 1, 1, 100);

    // invalid pattern while locked
    step(3'b000, 100, 0, 1, 1, 1, 1, 0, 100);
    step(3'b100, 110, 1, 0, 1, 0, 0, 0, 100);
    step(3'b110, 100, 1, 1, 1, 0, 0, 0, 110);
    step(3'b010, 100, 1, 2, 1, 0, 1, 0, 100);
    step(3'b011, 100, 1, 3, 1, 0, 1, 0, 100);
    step(3'b001, 100, 1, 4, 1, 0, 1, 0, 100);
    step(3'b101, 100, 1, 5, 1, 0, 1, 0, 100);
    step(3'b100, 100, 1, 0, 1, 0, 1, 0, 100);
    step(3'b110, 100, 1, 1, 1, 0, 1, 1, 100);
    chk("pre_reset_lock", 32'(locked), 1);

    // asynchronous reset while locked
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) @(negedge clk);
    {rgb_r, rgb_g, rgb_b} = 3'b010;
    q.push_back('{1, 2, 0, 0, 0, 0, -1});
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_hue_monitor.md
Name: rgb_hue_monitor

Overview:
- Receive-side counterpart of the six-hue RGB LED sequencer; it watches the three RGB drive lines and recovers the displayed hue.
- Synchronizes and glitch-filters the lines, then decodes the stable pattern to a hue index.
- Reports step direction, dwell time per hue, sequence errors, and a lock indication once the cycle is regular.
- Used on-board as a self-check and in the bench as the sequencer's scoreboard front end.

Parameters:
- SYNC_STAGES, 2, flip-flops in each input synchronizer (minimum 2).
- STABLE_CYCLES, 16, consecutive identical synced samples required to accept a pattern (minimum 1).
- DWELL_W, 24, width of dwell counter and dwell_cycles.
- NOMINAL_DWELL, 2_000_001, expected cycles per hue.
- DWELL_TOL, 1000, allowed absolute deviation from NOMINAL_DWELL.
- LOCK_STEPS, 6, consecutive good steps required for lock.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst_n  input  1  reset; asynchronous assert, active-low.
- rgb_r  input  1  red line, asynchronous to clk.
- rgb_g  input  1  green line, asynchronous to clk.
- rgb_b  input  1  blue line, asynchronous to clk.
- hue_valid  output  1  accepted pattern is one of the six hues.
- hue_idx  output  3  0=RED 100, 1=YELLOW 110, 2=GREEN 010, 3=CYAN 011, 4=BLUE 001, 5=MAGENTA 101 ({R,G,B}).
- hue_strobe  output  1  one-cycle pulse on each newly accepted pattern.
- dir_fwd  output  1  direction of the last valid step: 1 = +1 mod 6, 0 = -1 mod 6.
- seq_err  output  1  one-cycle pulse on an illegal step or invalid pattern.
- dwell_cycles  output  DWELL_W  cycles spent in the previous accepted pattern, saturating.
- dwell_ok  output  1  previous dwell is within NOMINAL_DWELL ± DWELL_TOL.
- locked  output  1  regular cycle detected.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs are 0; synchronizers, filter, dwell counter, run counter and FSM are cleared; FSM goes to IDLE. The accepted pattern resets to 000.
  - Reset mid-operation drops everything immediately.
  - After release, the first acceptance is treated as a first hue: no seq_err, dwell_ok=0.
- Filter:
  - `cand` holds the last synced pattern and `stab` counts cycles it has been held.
  - When the synced pattern differs from `cand`: load `cand`, set stab=0.
  - Otherwise `stab` increments, saturating.
  - Acceptance fires when stab reaches STABLE_CYCLES-1 and `cand` differs from the accepted pattern.
  - Input-change-to-strobe latency is SYNC_STAGES+STABLE_CYCLES+1 clocks. Pulses shorter than STABLE_CYCLES are never accepted.
- Acceptance (registered; all updates land in the hue_strobe cycle):
  - accepted pattern <= cand.
  - hue_valid <= (cand is not 000 and not 111).
  - hue_idx updates only if valid; it holds otherwise.
  - dwell_cycles <= dwell counter + 1, saturating at all-ones. The dwell counter then restarts at 0.
  - dwell_ok <= (|dwell - NOMINAL_DWELL| <= DWELL_TOL). Compute in DWELL_W+1 bits; no wrap.
- Dwell counter:
  - Increments every cycle and saturates at all-ones; does not wrap.
  - In IDLE, dwell_ok is forced to 0 on acceptance.
- FSM states: IDLE, TRACK, LOCKED.
  - IDLE, accept valid hue -> TRACK; run=0; no seq_err.
  - IDLE, accept invalid pattern -> stay in IDLE; no seq_err.
  - TRACK/LOCKED, accept invalid -> IDLE; pulse seq_err; run=0; locked=0.
  - TRACK/LOCKED, step +1 or -1 mod 6 -> dir_fwd updated.
    - If direction matches the previous step and dwell_ok: run++ (saturating at LOCK_STEPS).
    - If direction changed or !dwell_ok: run=1 if dwell_ok else 0.
  - TRACK/LOCKED, any other step -> pulse seq_err; run=0; TRACK.
  - run==LOCK_STEPS -> LOCKED and locked=1, asserted in the same cycle run reaches LOCK_STEPS.
  - LOCKED with run<LOCK_STEPS -> TRACK and locked=0.
- seq_err and hue_strobe only ever pulse together and last one cycle.

Decomposition:
- Package rgb_pkg:
  - hue_t enum (RED..MAGENTA, 3 bits) and NUM_HUES=6.
  - Pattern constants PAT_RED..PAT_MAGENTA, shared with the sequencer.
  - Functions pat_to_hue, hue_valid_pat, hue_next, hue_prev (mod 6).
  - FSM state enum mon_state_t.
- Sub-module rgb_glitch_filter: 3-bit SYNC_STAGES synchronizer plus the STABLE_CYCLES filter. Outputs are the accepted pattern and a one-cycle `accept` pulse.

Test Plan (override NOMINAL_DWELL=100, DWELL_TOL=2, STABLE_CYCLES=4, SYNC_STAGES=2):
- Reset: hold rst_n=0 with rgb=100 -> all outputs 0. Release -> hue_strobe 7 clocks after the first sampling edge, hue_idx=0, hue_valid=1, seq_err=0, dwell_ok=0.
- Forward sequence: RED..MAGENTA..RED, 100 cycles each -> dir_fwd=1, dwell_cycles=100, dwell_ok=1, locked=1 on the 6th step, no seq_err.
- Glitch: 3-cycle 110 pulse inside RED -> no hue_strobe, hue_idx stays 0. A 4-cycle pulse is accepted and gives a strobe.
- Reverse and skip: RED->MAGENTA->BLUE -> dir_fwd=0, no seq_err. Then BLUE->YELLOW -> seq_err pulse, locked=0, state TRACK.
- Invalid and dwell: 000 while locked -> hue_valid=0, seq_err, locked=0. In the next run, one dwell of 110 -> dwell_ok=0 and lock delayed until 6 further good steps.
- Mid-operation reset: assert rst_n while LOCKED -> all outputs 0 immediately. After release, the first hue gives no seq_err.
